// File: rtl/memory_arbiter_2p.sv
// memory_arbiter_2p
// Two-port round-robin arbiter and initialiser for a single-port synchronous
// memory (default 32 words x 4 bits). After every reset it writes INIT_VAL to
// every word, then shares the memory between requesters A and B. It never
// grants the same port in two consecutive cycles.
//
// Ports:
//   clk, reset               clock and synchronous active-high reset
//   req_x, wren_x            request (held until gnt_x) and write enable
//   addr_x, data_x           command address and write data
//   gnt_x                    one-cycle pulse: command accepted
//   rvalid_x                 one-cycle pulse, one cycle after a read grant
//   rdata                    shared read data, wired straight from mem_q
//   busy                     high during reset and initialisation
//   mem_addr/data/wren/q     memory interface
module memory_arbiter_2p #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              wren_a,
  input  logic              wren_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  // One extra counter bit marks "last address already issued".
  localparam logic [ADDR_W:0] CNT_DONE = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic              rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
  logic              mem_wren_q, mem_wren_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              last_b_q, last_b_d;   // 1: B won most recently
  logic              elig_a, elig_b, win_a, win_b;

  // A port whose grant is showing this cycle sits out one arbitration,
  // which also gives the requester time to drop or change its command.
  always_comb begin
    elig_a = req_a & ~gnt_a_q;
    elig_b = req_b & ~gnt_b_q;
    win_a  = elig_a & (~elig_b | last_b_q);
    win_b  = elig_b & ~win_a;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      if (cnt_q == CNT_DONE) state_d = ST_RUN;
      else                   cnt_d   = cnt_q + CNT_ONE;
    end
  end

  // Output logic (values registered on the next edge).
  always_comb begin
    busy_d     = busy_q;
    gnt_a_d    = 1'b0;
    gnt_b_d    = 1'b0;
    rvalid_a_d = 1'b0;
    rvalid_b_d = 1'b0;
    mem_wren_d = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    last_b_d   = last_b_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == CNT_DONE) begin
          busy_d = 1'b0;
        end else begin
          busy_d     = 1'b1;
          mem_wren_d = 1'b1;
          mem_addr_d = cnt_q[ADDR_W-1:0];
          mem_data_d = INIT_VAL;
        end
      end
      ST_RUN: begin
        busy_d = 1'b0;
        // During a gnt cycle mem_wren_q still holds the granted command's
        // direction, so a read's rvalid follows the grant by one cycle.
        rvalid_a_d = gnt_a_q & ~mem_wren_q;
        rvalid_b_d = gnt_b_q & ~mem_wren_q;
        if (win_a) begin
          gnt_a_d    = 1'b1;
          mem_wren_d = wren_a;
          mem_addr_d = addr_a;
          mem_data_d = data_a;
          last_b_d   = 1'b0;
        end else if (win_b) begin
          gnt_b_d    = 1'b1;
          mem_wren_d = wren_b;
          mem_addr_d = addr_b;
          mem_data_d = data_b;
          last_b_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      busy_q     <= 1'b1;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      mem_wren_q <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      last_b_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      gnt_a_q    <= gnt_a_d;
      gnt_b_q    <= gnt_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      mem_wren_q <= mem_wren_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      last_b_q   <= last_b_d;
    end
  end

  assign gnt_a    = gnt_a_q;
  assign gnt_b    = gnt_b_q;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign busy     = busy_q;
  assign mem_wren = mem_wren_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign rdata    = mem_q;

endmodule
